// File: rtl/fifo_6x8_flow.sv
// 6-entry x 8-bit synchronous FIFO with full/empty, almost thresholds,
// hysteretic pause back-pressure and a sticky overflow/underflow error flag.
module fifo_6x8_flow #(
    parameter int DATA_SIZE       = 8,
    parameter int MAIN_SIZE       = 6,
    parameter int ALMOST_FULL_TH  = 4,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_SIZE-1:0] data_in_push,
    output logic [DATA_SIZE-1:0] data_out_pop,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 fifo_pause,
    output logic                 fifo_error
);

    localparam int PTR_W = (MAIN_SIZE > 1) ? $clog2(MAIN_SIZE) : 1;
    localparam int CNT_W = $clog2(MAIN_SIZE + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAIN_SIZE);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(ALMOST_EMPTY_TH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAIN_SIZE - 1);

    generate
        if (!(ALMOST_EMPTY_TH < ALMOST_FULL_TH && ALMOST_FULL_TH <= MAIN_SIZE)) begin : g_bad_th
            $error("fifo_6x8_flow: thresholds must satisfy ALMOST_EMPTY_TH < ALMOST_FULL_TH <= MAIN_SIZE");
        end
    endgenerate

    logic [DATA_SIZE-1:0] mem [MAIN_SIZE];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     next_count;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 overflow;
    logic                 underflow;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == FULL_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A write into a full FIFO is still taken when a pop frees a slot the same cycle.
    assign wr_acc    = write && (!fifo_full || read);
    assign rd_acc    = read && !fifo_empty;
    assign overflow  = write && fifo_full && !read;
    assign underflow = read && fifo_empty;

    always_comb begin
        next_count = count;
        case ({wr_acc, rd_acc})
            2'b10:   next_count = count + 1'b1;
            2'b01:   next_count = count - 1'b1;
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out_pop <= '0;
            fifo_pause   <= 1'b0;
            fifo_error   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                data_out_pop <= mem[rd_ptr];
                rd_ptr       <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= next_count;
            // Pause holds between the two thresholds to avoid chattering.
            if (next_count >= AF_CNT) begin
                fifo_pause <= 1'b1;
            end else if (next_count <= AE_CNT) begin
                fifo_pause <= 1'b0;
            end
            if (overflow || underflow) begin
                fifo_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_6x8_flow.sv
// Directed testbench for fifo_6x8_flow: fill, overflow, drain past empty,
// full read+write with pointer wrap, and reset mid-operation.
module tb_fifo_6x8_flow;

    logic       clk;
    logic       reset;
    logic       write;
    logic       read;
    logic [7:0] data_in_push;
    logic [7:0] data_out_pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_pause;
    logic       fifo_error;

    int test_count = 0;
    int fail_count = 0;

    fifo_6x8_flow dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .read         (read),
        .data_in_push (data_in_push),
        .data_out_pop (data_out_pop),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_pause   (fifo_pause),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then waits past the rising edge before returning.
    task automatic applyStimulus(input logic rst, input logic w, input logic r, input logic [7:0] d);
        reset        = rst;
        write        = w;
        read         = r;
        data_in_push = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic e, input logic f, input logic af,
                              input logic ae, input logic p, input logic err);
        checkOutput({tag, ".empty"},        fifo_empty,   e);
        checkOutput({tag, ".full"},         fifo_full,    f);
        checkOutput({tag, ".almost_full"},  almost_full,  af);
        checkOutput({tag, ".almost_empty"}, almost_empty, ae);
        checkOutput({tag, ".pause"},        fifo_pause,   p);
        checkOutput({tag, ".error"},        fifo_error,   err);
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; read = 1'b0; data_in_push = 8'h00;

        // 1: reset with write and read asserted
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hAA);
        checkFlags("reset", 1, 0, 0, 1, 0, 0);
        checkOutput("reset.dout", data_out_pop, 8'h00);

        // 2: fill with 0x03..0x08; expected flags per count hand-listed
        begin
            logic [5:0] exp_ae  = 6'b000011;  // bit k-1 for push k
            logic [5:0] exp_af  = 6'b111000;
            logic [5:0] exp_ful = 6'b100000;
            for (int k = 0; k < 6; k++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h03 + k));
                checkFlags($sformatf("fill%0d", k + 1), 0, exp_ful[k], exp_af[k], exp_ae[k], exp_af[k], 0);
            end
        end

        // 3: overflow attempt with 0x09
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h09);
        checkFlags("overflow", 0, 1, 1, 0, 1, 1);

        // 3/4: drain; pause clears when count reaches 2
        begin
            logic [5:0] exp_p  = 6'b000111;  // bit i after pop i+1
            logic [5:0] exp_ae = 6'b111000;
            logic [5:0] exp_af = 6'b000011;
            logic [5:0] exp_e  = 6'b100000;
            for (int i = 0; i < 6; i++) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
                checkOutput($sformatf("drain%0d.dout", i + 1), data_out_pop, 32'(8'h03 + i));
                checkFlags($sformatf("drain%0d", i + 1), exp_e[i], 0, exp_af[i], exp_ae[i], exp_p[i], 1);
            end
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput($sformatf("underflow%0d.dout", i + 1), data_out_pop, 8'h08);
            checkFlags($sformatf("underflow%0d", i + 1), 1, 0, 0, 1, 0, 1);
        end

        // 5: reset, fill 0x10..0x15, read+write while full, then drain across wrap
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkFlags("rst2", 1, 0, 0, 1, 0, 0);
        checkOutput("rst2.dout", data_out_pop, 8'h00);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h10 + k));
        end
        checkFlags("full2", 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'(8'h16 + i));
            checkOutput($sformatf("rw%0d.dout", i + 1), data_out_pop, 32'(8'h10 + i));
            checkFlags($sformatf("rw%0d", i + 1), 0, 1, 1, 0, 1, 0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
            checkOutput($sformatf("wrap%0d.dout", i + 1), data_out_pop, 32'(8'h14 + i));
        end
        checkFlags("wrap.end", 1, 0, 0, 1, 0, 0);

        // 6: reset mid-operation discards buffered data
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h20 + k));
        end
        checkFlags("pre_rst", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkFlags("mid_rst", 1, 0, 0, 1, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("post_rst.dout", data_out_pop, 8'h00);
        checkFlags("post_rst", 1, 0, 0, 1, 0, 1);

        // Read+write on empty: write lands, read rejected, no pass-through
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
        checkOutput("rw_empty.dout", data_out_pop, 8'h00);
        checkFlags("rw_empty", 0, 0, 0, 1, 0, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        checkOutput("rw_empty_pop.dout", data_out_pop, 8'h33);
        checkFlags("rw_empty_pop", 1, 0, 0, 1, 0, 1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule

// File: doc/fifo_6x8_flow.md
Name: fifo_6x8_flow

Overview:
Synchronous 6-entry x 8-bit FIFO with flow-control flags. It is the receiving end of the push/pop interface that the FIFO test benches drive, and it sits between a port's ingress and its arbiter in the adaptive PCIe switch. Beyond the basic full/empty flags it provides almost_full/almost_empty thresholds, a hysteretic pause signal for upstream back-pressure, and a sticky overflow/underflow error flag.

Parameters:
DATA_SIZE, 8, word width in bits
MAIN_SIZE, 6, depth in entries; need not be a power of two
ALMOST_FULL_TH, 4, almost_full asserts when count >= this value
ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this value

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
write  input  1  push request
read  input  1  pop request
data_in_push  input  DATA_SIZE  push data, sampled on an accepted write
data_out_pop  output  DATA_SIZE  registered pop data
fifo_empty  output  1  count == 0
fifo_full  output  1  count == MAIN_SIZE
almost_full  output  1  count >= ALMOST_FULL_TH
almost_empty  output  1  count <= ALMOST_EMPTY_TH
fifo_pause  output  1  hysteretic back-pressure to the producer
fifo_error  output  1  sticky overflow/underflow flag

Behaviour:
- State: storage array, wr_ptr and rd_ptr (each clog2(MAIN_SIZE) bits), count (0..MAIN_SIZE), data_out_pop register, pause register, error register.
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset=1 sampled at a rising edge).
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out_pop=0, fifo_pause=0, fifo_error=0. Therefore fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0. Storage contents are don't-care.
- Reset has priority over read and write in the same cycle.
- Reset mid-operation: all buffered data is discarded at that edge and outputs return to their reset values.
- Flag timing: fifo_empty, fifo_full, almost_full and almost_empty decode combinationally from the registered count. They are valid immediately after the edge that changes count.
- Write acceptance: wr_acc = write && (!fifo_full || read).
  - On wr_acc: mem[wr_ptr] <= data_in_push.
  - wr_ptr advances; MAIN_SIZE-1 wraps to 0.
- Read acceptance: rd_acc = read && !fifo_empty.
  - On rd_acc: data_out_pop <= mem[rd_ptr] at the same edge (1-cycle latency: data is visible after the edge where read was sampled).
  - rd_ptr advances with the same wrap rule.
  - data_out_pop holds its value when no read is accepted.
- Count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Simultaneous read+write when full: both are accepted; the oldest word is popped, the new word is stored in the freed slot, count stays MAIN_SIZE, no error.
- Simultaneous read+write when empty: the write is accepted and the read is rejected (underflow). There is no pass-through; count becomes 1.
- Overflow: write && fifo_full && !read. The write is dropped, storage and pointers are unchanged, and fifo_error <= 1.
- Underflow: read && fifo_empty. No pop occurs, data_out_pop holds, and fifo_error <= 1.
- fifo_error is sticky and clears only on reset.
- fifo_pause (hysteresis), evaluated on next_count:
  - Set when next_count >= ALMOST_FULL_TH.
  - Cleared when next_count <= ALMOST_EMPTY_TH.
  - Otherwise holds.
  - With the defaults, pause asserts on the edge where count reaches 4 and deasserts on the edge where count falls to 2.
- Elaboration requirement: ALMOST_EMPTY_TH < ALMOST_FULL_TH <= MAIN_SIZE.
- fifo_pause is advisory only. Writes are still accepted while it is high, provided the FIFO is not full.

Test Plan:
1. Reset held 2 cycles, with write=1 and read=1 during reset -> count=0, fifo_empty=1, almost_empty=1, all other flags 0, data_out_pop=0.
2. Push 0x03..0x08 on 6 consecutive cycles ->
   - almost_empty drops after the 3rd push.
   - almost_full and fifo_pause rise after the 4th push.
   - fifo_full=1 after the 6th push.
   - fifo_error stays 0.
3. While full, write=1 with data 0x09 and read=0 -> fifo_error=1 (stays 1), count=6. Draining then yields 0x03,0x04,0x05,0x06,0x07,0x08 on consecutive cycles, each one edge after its read; 0x09 never appears.
4. Drain continued past empty (read held 2 extra cycles) ->
   - fifo_pause clears on the edge where count becomes 2.
   - fifo_empty=1 after the 6th pop.
   - data_out_pop holds 0x08 during the extra reads.
   - fifo_error=1.
5. After reset:
   - Push 0x10..0x15 (full), then read+write together for 4 cycles with data 0x16..0x19 -> count stays 6, pops are 0x10..0x13, no error.
   - Then drain -> 0x14,0x15,0x16,0x17,0x18,0x19, exercising pointer wrap.
6. Push 3 words, assert reset for 1 cycle, then read -> fifo_error=1 (underflow on the now-empty FIFO), data_out_pop=0, all flags at reset values.
